stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Datapath that consumes the stopwatch control FSM's `countUp`/`paused` outputs and keeps the elapsed time as a four-digit BCD value, SS.hh (00.00–99.99). It steps the value once per prescaled tick in the commanded direction and drives a time-multiplexed four-digit, active-low seven-segment display. It sits between the control FSM and the board display pins, in the same clock domain as the FSM.

## Interface

- `TICK_DIV`, 1_000_000 — clock cycles per count step (100 Hz at 100 MHz); ≥2
- `SCAN_DIV`, 100_000 — clock cycles each display digit is shown; ≥2
- `clk` in 1 — system clock; all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `countUp` in 1 — 1 = count up, 0 = count down (from control FSM)
- `paused` in 1 — 1 = hold value and prescaler (from control FSM)
- `digits` out 16 — BCD value {d3,d2,d1,d0}: tens-s, s, tenths, hundredths
- `zero` out 1 — 1 when `digits` == 16'h0000
- `an` out 4 — digit enables, active-low, one-hot; bit i = digit i
- `seg` out 7 — segments {g,f,e,d,c,b,a}, active-low
- `dp` out 1 — decimal point, active-low

## Operation

- Inputs are sampled directly. They are synchronous to `clk` (FSM state decode), so no synchronizer is used.
- **Prescaler:** counts 0..TICK_DIV-1 while `paused`=0. It wraps to 0 and asserts an internal `tick` in the cycle where it equals TICK_DIV-1. It holds its value while `paused`=1, so partial intervals are preserved. A direction change does not clear it.
- **Tick step, `countUp`=1:** BCD increment. A digit at 9 becomes 0 and carries. 99.99 wraps to 00.00.
- **Tick step, `countUp`=0:** BCD decrement. A digit at 0 becomes 9 and borrows, e.g. 10.00 → 09.99. At 00.00 the value saturates: no change, no wrap.
- `countUp` and `paused` are sampled in the tick cycle itself. If `paused` rises in the same cycle the prescaler reaches TICK_DIV-1, there is no tick and the prescaler holds at TICK_DIV-1.
- `zero` is combinational from `digits`.
- **Scan:** a free-running divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0. The scan runs regardless of `paused`.
- **Display outputs (registered from index and `digits`):**
  - `an` = ~(1<<index).
  - `seg` = active-low decode of the selected digit. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes A–F (unreachable) give 1111111.
  - `dp` = 0 only when index = 2, marking the point after the seconds digit; otherwise 1.
- **Reset values:** `digits`=0000, `zero`=1, prescaler=0, scan divider=0, index=0, `an`=1110, `seg`=1000000, `dp`=1.
- Reset has priority over tick and scan in the same cycle.

## Timing

- Tick cycle T (prescaler = TICK_DIV-1, `paused`=0): `digits` shows the new value after the edge ending cycle T. Latency is 1 cycle; `zero` follows in the same cycle as `digits`.
- Continuous run: exactly one step every TICK_DIV cycles. The first step after reset is TICK_DIV cycles after `rst` falls.
- Pause: cycles with `paused`=1 are not counted. Total cycles to a step = TICK_DIV unpaused cycles since the last step.
- Display: each digit is enabled for SCAN_DIV cycles. `an`/`seg`/`dp` update 1 cycle after the index changes, or 1 cycle after `digits` changes for the active digit.
- No glitches: `an` is always exactly one low bit after reset.

## Test plan

Bench parameters: TICK_DIV=4, SCAN_DIV=2.

1. **Count up from reset.** Release `rst`, `countUp`=1, `paused`=0 → `digits`=0001 at cycle 4, 0010 at cycle 40, 0100 at cycle 400; `zero` falls with the first step.
2. **Up wrap.** Run up 9999 steps, then 1 more → 9999 then 0000; `zero`=1.
3. **Down with borrow and saturation.** From 1000 set `countUp`=0 → next step gives 0999. From 0002 → 0001, 0000, then holds at 0000 for further ticks; `zero`=1.
4. **Pause preserves partial interval.** Set `paused`=1 when the prescaler is 2 and hold 10 cycles, then release → `digits` unchanged during pause; step lands on the 2nd edge after `paused` falls.
5. **Display scan.** Hold `digits`=1234 with `paused`=1 → `an` cycles 1110, 1101, 1011, 0111, each for 2 cycles. `seg` shows 0011001, 0110000, 0100100, 1111001 respectively; `dp`=0 only while `an`=1011.
6. **Reset mid-operation.** Assert `rst` for 1 cycle while `digits`=0573 and scan index=3 → next cycle `digits`=0000, `zero`=1, `an`=1110, `seg`=1000000, `dp`=1; counting resumes with the first step 4 cycles later.

Source files
------------

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : Four-digit BCD elapsed-time datapath (SS.hh, 00.00-99.99) that
//            steps once per prescaled tick. It counts up with wrap, or down
//            with saturation at zero. It also drives a time-multiplexed,
//            active-low four-digit seven-segment display.
// Ports    : clk      - system clock, all state on rising edge
//            rst      - synchronous active-high reset
//            countUp  - 1 = count up, 0 = count down
//            paused   - 1 = hold value and prescaler
//            digits   - BCD value {tens-s, s, tenths, hundredths}
//            zero     - 1 when digits == 0000
//            an       - digit enables, active-low one-hot
//            seg      - segments {g,f,e,d,c,b,a}, active-low
//            dp       - decimal point, active-low
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int TICK_DIV = 1_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        countUp,
  input  logic        paused,
  output logic [15:0] digits,
  output logic        zero,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    index;
  logic [3:0]    sel_digit;

  // BCD increment: each 9 rolls to 0 and carries; 99.99 wraps to 00.00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement: each 0 rolls to 9 and borrows; 00.00 saturates.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = (v != 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    sel_digit = digits[3:0];
    case (index)
      2'd0:    sel_digit = digits[3:0];
      2'd1:    sel_digit = digits[7:4];
      2'd2:    sel_digit = digits[11:8];
      default: sel_digit = digits[15:12];
    endcase
  end

  assign zero = (digits == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      digits   <= 16'h0000;
      scan_cnt <= '0;
      index    <= 2'd0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
      dp       <= 1'b1;
    end else begin
      // A pause that coincides with the terminal count suppresses the tick
      // and holds the prescaler at its last value.
      if (!paused) begin
        if (presc == TICK_LAST) begin
          presc  <= '0;
          digits <= countUp ? bcd_inc(digits) : bcd_dec(digits);
        end else begin
          presc <= presc + TW'(1);
        end
      end

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        index    <= index + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end

      an  <= ~(4'b0001 << index);
      seg <= seg_decode(sel_digit);
      dp  <= (index != 2'd2);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_counter
// Purpose  : Self-checking bench for stopwatch_counter (TICK_DIV=4,
//            SCAN_DIV=2). It applies directed vectors, corner sequences and a
//            randomized run against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        count_up = 1'b1;
  logic        paused = 1'b0;
  logic [15:0] digits;
  logic        zero;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .countUp(count_up), .paused(paused),
    .digits(digits), .zero(zero), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed value as a plain integer 0..9999
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_at(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(digit_at(v, 3)), 4'(digit_at(v, 2)), 4'(digit_at(v, 1)), 4'(digit_at(v, 0))};
  endfunction

  int         m_val = 0;
  int         m_pre = 0;
  int         m_scan = 0;
  int         m_idx = 0;
  logic [3:0] m_an = 4'b1110;
  logic [6:0] m_seg = 7'b1000000;
  logic       m_dp = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_val <= 0; m_pre <= 0; m_scan <= 0; m_idx <= 0;
      m_an <= 4'b1110; m_seg <= 7'b1000000; m_dp <= 1'b1;
    end else begin
      m_an  <= ~(4'b0001 << m_idx);
      m_seg <= seg_of(digit_at(m_val, m_idx));
      m_dp  <= (m_idx != 2);
      if (!paused) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre <= 0;
          if (count_up) m_val <= (m_val + 1) % 10000;
          else          m_val <= (m_val == 0) ? 0 : m_val - 1;
        end else begin
          m_pre <= m_pre + 1;
        end
      end
      if (m_scan == SCAN_DIV - 1) begin
        m_scan <= 0;
        m_idx  <= (m_idx + 1) % 4;
      end else begin
        m_scan <= m_scan + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits until `an` shows the given pattern; an expired budget is a failure.
  task automatic wait_an(input logic [3:0] target);
    for (int i = 0; i < 16; i++) begin
      run(1);
      if (an === target) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_an timeout actual=%b required=%b", an, target);
  endtask

  typedef struct {
    logic        r;
    logic        up;
    logic        p;
    int          n;
    logic [15:0] exp_digits;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic up, input logic p, input int n,
                     input logic [15:0] d, input logic z);
    vec_t v;
    v.r = r; v.up = up; v.p = p; v.n = n; v.exp_digits = d; v.exp_zero = z;
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
  } disp_t;

  disp_t scan_tab[4];

  initial begin
    // Count up from reset, up wrap, down borrow and saturation
    add(1, 1, 0, 1,     16'h0000, 1);
    add(0, 1, 0, 3,     16'h0000, 1);
    add(0, 1, 0, 1,     16'h0001, 0);
    add(0, 1, 0, 36,    16'h0010, 0);
    add(0, 1, 0, 360,   16'h0100, 0);
    add(0, 1, 0, 39596, 16'h9999, 0);
    add(0, 1, 0, 4,     16'h0000, 1);
    add(0, 1, 0, 4000,  16'h1000, 0);
    add(0, 0, 0, 4,     16'h0999, 0);
    add(0, 0, 0, 3988,  16'h0002, 0);
    add(0, 0, 0, 4,     16'h0001, 0);
    add(0, 0, 0, 4,     16'h0000, 1);
    add(0, 0, 0, 8,     16'h0000, 1);

    scan_tab[0] = '{4'b1110, 7'b0011001, 1'b1};
    scan_tab[1] = '{4'b1101, 7'b0110000, 1'b1};
    scan_tab[2] = '{4'b1011, 7'b0100100, 1'b0};
    scan_tab[3] = '{4'b0111, 7'b1111001, 1'b1};

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r; count_up = vecs[i].up; paused = vecs[i].p;
      run(vecs[i].n);
      chk($sformatf("vec%0d digits", i), digits, vecs[i].exp_digits);
      chk($sformatf("vec%0d zero", i), zero, vecs[i].exp_zero);
    end
    chk("reset an after run", an, m_an);

    // Pause at prescaler=2 keeps the partial interval
    count_up = 1; paused = 0;
    run(2);  chk("pre-pause digits", digits, 16'h0000);
    paused = 1;
    run(10); chk("during pause digits", digits, 16'h0000);
    paused = 0;
    run(1);  chk("1st edge after pause", digits, 16'h0000);
    run(1);  chk("2nd edge after pause", digits, 16'h0001);
    // Pause rising on the terminal-count cycle suppresses the tick
    run(3);  chk("at terminal count", digits, 16'h0001);
    paused = 1;
    run(2);  chk("pause at terminal", digits, 16'h0001);
    paused = 0;
    run(1);  chk("held terminal ticks", digits, 16'h0002);

    // Display scan with 12.34
    rst = 1; run(1); rst = 0;
    run(4936); chk("reach 1234", digits, 16'h1234);
    paused = 1;
    run(1); chk("hold 1234", digits, 16'h1234);
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int e = 0; e < 4; e++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("scan%0d_%0d an", e, c), an, scan_tab[e].a);
        chk($sformatf("scan%0d_%0d seg", e, c), seg, scan_tab[e].s);
        chk($sformatf("scan%0d_%0d dp", e, c), dp, scan_tab[e].d);
        run(1);
      end
    end

    // Reset mid-operation at 05.73 with scan index 3
    paused = 0; rst = 1; run(1); rst = 0;
    run(2292); chk("reach 0573", digits, 16'h0573);
    paused = 1;
    wait_an(4'b1011);
    wait_an(4'b0111);
    rst = 1; run(1);
    chk("midrst digits", digits, 16'h0000);
    chk("midrst zero", zero, 1'b1);
    chk("midrst an", an, 4'b1110);
    chk("midrst seg", seg, 7'b1000000);
    chk("midrst dp", dp, 1'b1);
    rst = 0; paused = 0; count_up = 1;
    run(3); chk("post-rst no step", digits, 16'h0000);
    run(1); chk("post-rst first step", digits, 16'h0001);

    // Randomized run against the reference model
    for (int i = 0; i < 2000; i++) begin
      chk("rand digits", digits, to_bcd(m_val));
      chk("rand zero", zero, (m_val == 0));
      chk("rand an", an, m_an);
      chk("rand seg", seg, m_seg);
      chk("rand dp", dp, m_dp);
      rst      = ($urandom_range(0, 255) == 0);
      paused   = ($urandom_range(0, 3) == 0);
      count_up = ($urandom_range(0, 3) != 0);
      run(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
